reg_file_sb: RTL and testbench

- Parametrised successor to the core integer register file.
- Configurable data width, register count and number of asynchronous read ports.
- Clocked write port replaces the write-enable-edge write.
- Adds a per-register busy scoreboard so the issue stage can reserve a destination and the writeback stage can release it. Required for multicycle and pipelined execution.
- Sits between decode/issue (read, reserve) and writeback (write, release).

---
 rtl/reg_file_pkg.sv | 14 +
 rtl/sb_tracker.sv | 55 +++++
 rtl/reg_file_sb.sv | 71 +++++++
 tb/tb_reg_file_sb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the scoreboarded integer register file.
package reg_file_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned NRD_DEF   = 2;
  localparam int unsigned ZERO_REG  = 0;

  // Address width needed to index n registers.
  function automatic int unsigned calc_aw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sb_tracker.sv
// Busy scoreboard: per-register busy bits, reservation acceptance and a
// registered count of busy registers.
module sb_tracker
  import reg_file_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = calc_aw(NREGS_DEF),
  parameter int unsigned CW    = calc_aw(NREGS_DEF) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w_en,
  input  logic [AW-1:0]    wa,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [NREGS-1:0] busy,
  output logic             rsv_ok_c,
  output logic [CW-1:0]    busy_cnt
);

  logic             wr_c;
  logic             release_c;
  logic             reserve_c;
  logic [NREGS-1:0] busy_nxt;

  assign wr_c      = w_en && (wa != AW'(ZERO_REG));
  assign release_c = wr_c && busy[wa];
  assign rsv_ok_c  = rsv_en && ((rsv_addr == AW'(ZERO_REG)) || !busy[rsv_addr] ||
                                (w_en && (wa == rsv_addr)));
  assign reserve_c = rsv_ok_c && (rsv_addr != AW'(ZERO_REG));

  // Release is applied first so a same-address reservation wins.
  always_comb begin
    busy_nxt = busy;
    if (wr_c) busy_nxt[wa] = 1'b0;
    if (reserve_c) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      // A reservation only lands on a free (or just-released) bit, so the
      // count moves by reserve minus release.
      case ({reserve_c, release_c})
        2'b10:   busy_cnt <= busy_cnt + CW'(1);
        2'b01:   busy_cnt <= busy_cnt - CW'(1);
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised integer register file with async read ports, clocked write
// and busy scoreboard. Define REG_FILE_SB_BYPASS_EN for write-to-read forwarding.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = NRD_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NRD*calc_aw(NREGS)-1:0]      ra,
  output logic [NRD*XLEN-1:0]                rd,
  output logic [NRD-1:0]                     rd_busy,
  input  logic                               w_en,
  input  logic [calc_aw(NREGS)-1:0]          wa,
  input  logic [XLEN-1:0]                    wd,
  input  logic                               rsv_en,
  input  logic [calc_aw(NREGS)-1:0]          rsv_addr,
  output logic                               rsv_ok,
  output logic [calc_aw(NREGS):0]            busy_cnt
);

  localparam int unsigned AW = calc_aw(NREGS);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  sb_tracker #(
    .NREGS (NREGS),
    .AW    (AW),
    .CW    (CW)
  ) u_sb_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .rsv_ok_c (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  // Register 0 is never written, so its storage stays at the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NREGS; k++) regs[k] <= '0;
    end else if (w_en && (wa != AW'(ZERO_REG))) begin
      regs[wa] <= wd;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          is_zero;
    logic          fwd;

    assign a       = ra[i*AW +: AW];
    assign is_zero = (a == AW'(ZERO_REG));
`ifdef REG_FILE_SB_BYPASS_EN
    assign fwd     = w_en && (wa == a);
`else
    assign fwd     = 1'b0;
`endif
    assign rd[i*XLEN +: XLEN] = is_zero ? '0 : (fwd ? wd : regs[a]);
    assign rd_busy[i]         = !is_zero && !fwd && busy[a];
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NRD  = 2;
`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NRD*AW-1:0]    ra;
  logic [NRD*XLEN-1:0]  rd;
  logic [NRD-1:0]       rd_busy;
  logic                 w_en;
  logic [AW-1:0]        wa;
  logic [XLEN-1:0]      wd;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic                 rsv_ok;
  logic [AW:0]          busy_cnt;

  int checks = 0;
  int errors = 0;

  reg_file_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra       (ra),
    .rd       (rd),
    .rd_busy  (rd_busy),
    .w_en     (w_en),
    .wa       (wa),
    .wd       (wd),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0; wa = '0; wd = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    ra = '0;
    idle();
    #2 rst_n = 1'b0;
    // Write attempted while reset is held must have no effect.
    w_en = 1'b1; wa = 5'd5; wd = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick(); tick();
    idle();
    for (int r = 0; r < 32; r++) begin
      set_ra(5'(r), 5'(31 - r));
      check("rst_rd0", 64'(rd[31:0]), 64'h0);
      check("rst_rd1", 64'(rd[63:32]), 64'h0);
      check("rst_busy", 64'(rd_busy), 64'h0);
    end
    check("rst_cnt", 64'(busy_cnt), 64'h0);
    rst_n = 1'b1;
    tick();

    // Write x5; same-cycle read shows forwarded or old data.
    w_en = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
    set_ra(5'd5, 5'd0);
    check("wr_cycle_rd", 64'(rd[31:0]), BYP ? 64'hDEAD_BEEF : 64'h0);
    tick();
    idle();
    set_ra(5'd5, 5'd5);
    check("x5_rd0", 64'(rd[31:0]), 64'hDEAD_BEEF);
    check("x5_rd1", 64'(rd[63:32]), 64'hDEAD_BEEF);
    check("x5_busy", 64'(rd_busy), 64'h0);

    // x0 is hardwired zero.
    w_en = 1'b1; wa = 5'd0; wd = 32'h1234;
    tick();
    idle();
    set_ra(5'd0, 5'd5);
    check("x0_rd", 64'(rd[31:0]), 64'h0);
    check("x0_cnt", 64'(busy_cnt), 64'h0);

    // Reserve x7, retry on busy, then release by writeback.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    #1 check("rsv7_ok", 64'(rsv_ok), 64'h1);
    tick();
    set_ra(5'd7, 5'd0);
    check("x7_busy", 64'(rd_busy), 64'h1);
    check("x7_cnt", 64'(busy_cnt), 64'h1);
    check("rsv7_again_ok", 64'(rsv_ok), 64'h0);
    tick();
    check("x7_cnt_hold", 64'(busy_cnt), 64'h1);
    idle();
    w_en = 1'b1; wa = 5'd7; wd = 32'h55;
    tick();
    idle();
    set_ra(5'd7, 5'd7);
    check("x7_rd", 64'(rd[31:0]), 64'h55);
    check("x7_rel_busy", 64'(rd_busy), 64'h0);
    check("x7_rel_cnt", 64'(busy_cnt), 64'h0);

    // Same-address release and reservation: reservation wins.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle();
    check("x9_cnt", 64'(busy_cnt), 64'h1);
    w_en = 1'b1; wa = 5'd9; wd = 32'hA5;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_ra(5'd0, 5'd9);
    check("x9_same_ok", 64'(rsv_ok), 64'h1);
    check("x9_wr_cycle_rd", 64'(rd[63:32]), BYP ? 64'hA5 : 64'h0);
    check("x9_wr_cycle_busy", 64'(rd_busy), BYP ? 64'h0 : 64'h2);
    tick();
    idle();
    set_ra(5'd9, 5'd0);
    check("x9_rd", 64'(rd[31:0]), 64'hA5);
    check("x9_busy", 64'(rd_busy), 64'h1);
    check("x9_cnt_same", 64'(busy_cnt), 64'h1);

    // Different addresses: release x9, reserve x10 together.
    w_en = 1'b1; wa = 5'd9; wd = 32'h9;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    #1 check("x10_ok", 64'(rsv_ok), 64'h1);
    tick();
    idle();
    set_ra(5'd9, 5'd10);
    check("x9_x10_busy", 64'(rd_busy), 64'h2);
    check("x9_x10_cnt", 64'(busy_cnt), 64'h1);
    w_en = 1'b1; wa = 5'd10; wd = 32'h10;
    tick();
    idle();
    check("x10_rel_cnt", 64'(busy_cnt), 64'h0);

    // Write to non-busy x3: no underflow; forwarding check.
    w_en = 1'b1; wa = 5'd3; wd = 32'h77;
    set_ra(5'd3, 5'd0);
    check("x3_wr_cycle_rd", 64'(rd[31:0]), BYP ? 64'h77 : 64'h0);
    tick();
    idle();
    check("x3_rd", 64'(rd[31:0]), 64'h77);
    check("x3_cnt", 64'(busy_cnt), 64'h0);

    // Reservation of x0 is accepted but reserves nothing.
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1 check("rsv0_ok", 64'(rsv_ok), 64'h1);
    tick();
    idle();
    check("rsv0_cnt", 64'(busy_cnt), 64'h0);

    // Fill the scoreboard, then async reset mid-cycle.
    for (int r = 1; r < 32; r++) begin
      rsv_en = 1'b1; rsv_addr = 5'(r);
      tick();
      if (r == 16) check("fill_cnt16", 64'(busy_cnt), 64'd16);
    end
    idle();
    check("fill_cnt", 64'(busy_cnt), 64'd31);
    set_ra(5'd31, 5'd1);
    check("fill_busy", 64'(rd_busy), 64'h3);
    rsv_en = 1'b1; rsv_addr = 5'd4;
    #1 check("full_rsv_ok", 64'(rsv_ok), 64'h0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cnt", 64'(busy_cnt), 64'h0);
    check("arst_busy", 64'(rd_busy), 64'h0);
    set_ra(5'd3, 5'd5);
    check("arst_rd", 64'(rd), 64'h0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_cnt", 64'(busy_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
